// File: rtl/mem_stage_responder.sv
// ---------------------------------------------------------------------------
// mem_stage_responder
//   MEM-stage responder for the decoder's LDR/STR memory-control interface.
//   Services one access at a time from an internal word memory with a fixed
//   latency of WAIT_CYCLES cycles. ready drops while an access is in flight.
//   The pipeline freezes while ready is low.
//
//   Optional feature macro: MEM_ADDR_CHECK_EN.
//   When it is defined, a misaligned or out-of-window address is flagged on
//   err and the access is suppressed. When it is undefined, err is tied to 0
//   and out-of-window addresses alias into the memory.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   mem_r_en  in   load request, held by upstream until ready
//   mem_w_en  in   store request, held by upstream until ready (wins over load)
//   addr      in   byte address from EXE
//   wdata     in   store data
//   rdata     out  registered load data, valid in DONE, held until next read
//   ready     out  1 = idle with no request, or access completing
//   err       out  address-fault pulse during DONE
// ---------------------------------------------------------------------------
module mem_stage_responder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [DATA_W-1:0] LO_ADDR = DATA_W'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_wr;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_req;
    logic [DATA_W-1:0]  w_off;
    logic [IDX_W-1:0]   w_idx;
    logic               w_fin;
    logic               w_fault;   // fault seen on the live address (acceptance)
    logic               w_flt_q;   // fault latched for the in-flight access
    logic               w_mem_we;
    logic               w_unused;

    assign w_req = mem_r_en | mem_w_en;
    // Wrapping subtraction; the low two bits and everything above the index
    // drop out, which gives the mod-DEPTH aliasing for free.
    assign w_off    = addr - LO_ADDR;
    assign w_idx    = w_off[IDX_W+1:2];
    assign w_unused = ^{w_off[DATA_W-1:IDX_W+2], w_off[1:0]};

    assign w_fin    = (r_state == S_ACCESS) && (r_cnt == '0);
    assign w_mem_we = w_fin && r_wr && !w_flt_q;
    assign ready    = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
    assign rdata    = r_rdata;

`ifdef MEM_ADDR_CHECK_EN
    localparam logic [DATA_W-1:0] HI_ADDR = DATA_W'(BASE_ADDR + 4 * DEPTH);

    logic r_fault;
    logic r_err;

    assign w_fault = (addr[1:0] != 2'b00) || (addr < LO_ADDR) || (addr >= HI_ADDR);
    assign w_flt_q = r_fault;
    assign err     = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_req) r_fault <= w_fault;
            // err is high for exactly the DONE cycle
            r_err <= w_fin && r_fault;
        end
    end
`else
    assign w_fault = 1'b0;
    assign w_flt_q = w_fault;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx   <= w_idx;
                        r_wdata <= wdata;
                        r_wr    <= mem_w_en;
                        r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        if (!r_wr) r_rdata <= w_flt_q ? '0 : r_mem[r_idx];
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                // The request still visible in DONE is the one just served
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory contents survive reset. A write is committed only from ACCESS,
    // which reset leaves immediately, so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_idx] <= r_wdata;
    end

endmodule

// File: tb/tb_mem_stage_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_responder
//   Directed bench for mem_stage_responder with default parameters
//   (WAIT_CYCLES=3, BASE_ADDR=1024, DEPTH=64). Expected values are written
//   inline; MEM_ADDR_CHECK_EN selects the fault-checking expectations.
// ---------------------------------------------------------------------------
module tb_mem_stage_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] g_rdata;
    logic [31:0] g_err;
    int          g_lows;

`ifdef MEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    mem_stage_responder dut (
        .clk      (clk),
        .rst      (rst),
        .mem_r_en (mem_r_en),
        .mem_w_en (mem_w_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Present a request just after a rising edge
    task automatic start(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        mem_r_en = rd; mem_w_en = wr; addr = a; wdata = d;
    endtask

    // Count low-ready cycles up to the DONE cycle; returns at DONE's falling edge
    task automatic wait_done(input string tag);
        g_lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) break;
            g_lows++;
        end
        chk({tag, "_lows"}, 32'(g_lows), 32'd4);
        g_rdata = rdata;
        g_err   = 32'(err);
    endtask

    task automatic drop();
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        start(rd, wr, a, d);
        wait_done(tag);
        drop();
    endtask

    initial begin
        logic [31:0] mem0;
        logic [31:0] prev;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // 1: store then load at BASE
        xfer("t1_str", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        chk("t1_str_err", g_err, 32'd0);
        @(negedge clk);
        chk("t1_idle_ready", 32'(ready), 32'd1);
        xfer("t1_ldr", 1'b1, 1'b0, 32'd1024, 32'h0);
        chk("t1_ldr_rdata", g_rdata, 32'hDEADBEEF);

        // 2: load held through DONE then dropped -> single access
        start(1'b1, 1'b0, 32'd1024, 32'h0);
        wait_done("t2_ldr");
        chk("t2_rdata", g_rdata, 32'hDEADBEEF);
        drop();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_idle_ready", 32'(ready), 32'd1);
        end
        // held continuously: second access only starts from IDLE
        start(1'b1, 1'b0, 32'd1024, 32'h0);
        wait_done("t2_held_a");
        wait_done("t2_held_b");
        drop();

        // 3: store at BASE+4*DEPTH
        xfer("t3_str", 1'b0, 1'b1, 32'd1280, 32'h1234);
        chk("t3_err", g_err, CHK ? 32'd1 : 32'd0);
        @(negedge clk);
        chk("t3_err_clr", 32'(err), 32'd0);
        mem0 = CHK ? 32'hDEADBEEF : 32'h1234;
        xfer("t3_ldr", 1'b1, 1'b0, 32'd1024, 32'h0);
        chk("t3_mem0", g_rdata, mem0);
        chk("t3_ldr_err", g_err, 32'd0);

        // 4: both enables -> write, rdata untouched
        prev = mem0;
        xfer("t4_both", 1'b1, 1'b1, 32'd1028, 32'hA5A5A5A5);
        chk("t4_rdata_held", g_rdata, prev);
        xfer("t4_ldr", 1'b1, 1'b0, 32'd1028, 32'h0);
        chk("t4_mem1", g_rdata, 32'hA5A5A5A5);

        // 5: reset during the 2nd ACCESS cycle discards the store
        xfer("t5_pre", 1'b0, 1'b1, 32'd1032, 32'h5555);
        start(1'b0, 1'b1, 32'd1032, 32'hFFFF);
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        @(negedge clk);
        chk("t5_rdata", rdata, 32'd0);
        chk("t5_ready", 32'(ready), 32'd1);
        chk("t5_err",   32'(err), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        xfer("t5_ldr", 1'b1, 1'b0, 32'd1032, 32'h0);
        chk("t5_mem2", g_rdata, 32'h5555);

        // 6: misaligned load
        xfer("t6_ldr", 1'b1, 1'b0, 32'd1026, 32'h0);
        chk("t6_rdata", g_rdata, CHK ? 32'd0 : mem0);
        chk("t6_err",   g_err, CHK ? 32'd1 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
